// File: rtl/param_cpu_pkg.sv
// Shared types and instruction-field helpers for the parametrised multi-cycle CPU.
// Field helpers take the register-index width so one package serves every NREG.
package param_cpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_JMZ  = 3'd1,
    OP_AND  = 3'd2,
    OP_XOR  = 3'd3,
    OP_SUB  = 3'd4,
    OP_LDI  = 3'd5,
    OP_OUT  = 3'd6,
    OP_HALT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_OUT_WAIT
  } state_e;

  localparam int unsigned MAX_INSTR_W = 32;
  typedef logic [MAX_INSTR_W-1:0] instr_t;

  // slot 0 = dst, 1 = src2, 2 = src1; opcode sits above slot 2
  function automatic instr_t get_field(instr_t ir, int unsigned rw, int unsigned slot);
    instr_t mask;
    mask = (instr_t'(1) << rw) - instr_t'(1);
    return (ir >> (slot * rw)) & mask;
  endfunction

  function automatic instr_t get_dst(instr_t ir, int unsigned rw);
    return get_field(ir, rw, 0);
  endfunction

  function automatic instr_t get_src2(instr_t ir, int unsigned rw);
    return get_field(ir, rw, 1);
  endfunction

  function automatic instr_t get_src1(instr_t ir, int unsigned rw);
    return get_field(ir, rw, 2);
  endfunction

  function automatic op_e get_op(instr_t ir, int unsigned rw);
    return op_e'(3'(ir >> (3 * rw)));
  endfunction

endpackage

// File: rtl/param_cpu_regfile.sv
// NREG x DATA_W register file: two combinational read ports, one clocked write port.
// Synchronous reset leaves r0 = 1 and every other register 0.
module param_cpu_regfile #(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned NREG   = 8,
  localparam int unsigned RW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RW-1:0]     ra1,
  input  logic [RW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [RW-1:0]     wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == 0) ? DATA_W'(1) : '0;
      end
    end else if (we) begin
      regs_q[wa] <= wd;
    end
  end

  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];

endmodule

// File: rtl/param_mcycle_cpu.sv
// Multi-cycle CPU core: host-loaded program RAM, FETCH/EXEC sequencing, ALU, and a
// valid/ready OUT channel. Runs from start until a HALT instruction retires.
module param_mcycle_cpu
  import param_cpu_pkg::*;
#(
  parameter  int unsigned DATA_W     = 4,
  parameter  int unsigned NREG       = 8,
  parameter  int unsigned PROG_DEPTH = 8,
  localparam int unsigned RW         = $clog2(NREG),
  localparam int unsigned PC_W       = $clog2(PROG_DEPTH),
  localparam int unsigned INSTR_W    = 3 + 3 * RW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  output logic               busy,
  output logic               halted,
  output logic [PC_W-1:0]    pc_out,
  output logic               retire,
  output logic               jmp_taken,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                retire_q, retire_d;
  logic                jmp_q, jmp_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic [INSTR_W-1:0]  prog_mem [PROG_DEPTH];

  op_e                 op;
  logic [RW-1:0]       src1, src2, dst;
  logic [2*RW-1:0]     imm;
  logic [DATA_W-1:0]   rd1, rd2, alu_res;
  logic                rf_we;

  always_comb begin
    op   = get_op(instr_t'(ir_q), RW);
    src1 = RW'(get_src1(instr_t'(ir_q), RW));
    src2 = RW'(get_src2(instr_t'(ir_q), RW));
    dst  = RW'(get_dst(instr_t'(ir_q), RW));
    imm  = {src1, src2};
  end

  param_cpu_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (src1),
    .ra2   (src2),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (rf_we),
    .wa    (dst),
    .wd    (alu_res)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = rd1 + rd2;
      OP_AND:  alu_res = rd1 & rd2;
      OP_XOR:  alu_res = rd1 ^ rd2;
      OP_SUB:  alu_res = rd1 - rd2;
      OP_LDI:  alu_res = DATA_W'(imm);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    halted_d    = halted_q;
    retire_d    = 1'b0;
    jmp_d       = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rf_we       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          pc_d     = '0;
          halted_d = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = prog_mem[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_JMZ: begin
            retire_d = 1'b1;
            state_d  = S_FETCH;
            if (rd1 == '0) begin
              pc_d  = PC_W'(rd2);
              jmp_d = 1'b1;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
          OP_OUT: begin
            state_d     = S_OUT_WAIT;
            out_valid_d = 1'b1;
            out_data_d  = rd1;
          end
          OP_HALT: begin
            retire_d = 1'b1;
            halted_d = 1'b1;
            state_d  = S_IDLE;
          end
          default: begin
            rf_we    = 1'b1;
            retire_d = 1'b1;
            pc_d     = pc_q + 1'b1;
            state_d  = S_FETCH;
          end
        endcase
      end
      S_OUT_WAIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          retire_d    = 1'b1;
          pc_d        = pc_q + 1'b1;
          state_d     = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      retire_q    <= 1'b0;
      jmp_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      retire_q    <= retire_d;
      jmp_q       <= jmp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // NOTE: program RAM has no reset so it maps onto plain memory and survives a core reset.
  always_ff @(posedge clk) begin
    if (rst_n && prog_we && (state_q == S_IDLE)) begin
      prog_mem[prog_addr] <= prog_wdata;
    end
  end

  assign busy      = busy_q;
  assign halted    = halted_q;
  assign pc_out    = pc_q;
  assign retire    = retire_q;
  assign jmp_taken = jmp_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_param_mcycle_cpu.sv
// Bench for param_mcycle_cpu: directed programs plus random programs checked against
// an instruction-level model of the ISA; one wide-parameter instance for the LDI/OUT path.
module tb_param_mcycle_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [2:0]  prog_addr = '0;
  logic [11:0] prog_wdata = '0;
  logic        busy, halted, retire, jmp_taken, out_valid;
  logic [2:0]  pc_out;
  logic [3:0]  out_data;
  logic        out_ready = 1'b0;

  logic        w_start = 1'b0;
  logic        w_prog_we = 1'b0;
  logic [3:0]  w_prog_addr = '0;
  logic [14:0] w_prog_wdata = '0;
  logic        w_busy, w_halted, w_retire, w_jmp_taken, w_out_valid;
  logic [3:0]  w_pc_out;
  logic [7:0]  w_out_data;
  logic        w_out_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  int unsigned m_reg [8];
  logic [11:0] m_prog [8];
  int          m_pc;
  bit          m_halt;
  int          outs [$];

  always #5 clk = ~clk;

  param_mcycle_cpu dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .busy(busy), .halted(halted), .pc_out(pc_out), .retire(retire),
    .jmp_taken(jmp_taken), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  param_mcycle_cpu #(.DATA_W(8), .NREG(16), .PROG_DEPTH(16)) dut_wide (
    .clk(clk), .rst_n(rst_n), .start(w_start), .prog_we(w_prog_we), .prog_addr(w_prog_addr),
    .prog_wdata(w_prog_wdata), .busy(w_busy), .halted(w_halted), .pc_out(w_pc_out),
    .retire(w_retire), .jmp_taken(w_jmp_taken), .out_valid(w_out_valid),
    .out_data(w_out_data), .out_ready(w_out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] enc(input int op, input int s1, input int s2, input int d);
    return {op[2:0], s1[2:0], s2[2:0], d[2:0]};
  endfunction

  // Executes the instruction at m_pc according to the ISA rules.
  task automatic model_step(output bit jumped);
    logic [11:0] w;
    int op, s1, s2, d;
    w = m_prog[m_pc];
    op = int'(w[11:9]); s1 = int'(w[8:6]); s2 = int'(w[5:3]); d = int'(w[2:0]);
    jumped = 1'b0;
    case (op)
      0: begin m_reg[d] = (m_reg[s1] + m_reg[s2]) % 16; m_pc = (m_pc + 1) % 8; end
      1: begin
        if (m_reg[s1] == 0) begin m_pc = int'(m_reg[s2] % 8); jumped = 1'b1; end
        else m_pc = (m_pc + 1) % 8;
      end
      2: begin m_reg[d] = m_reg[s1] & m_reg[s2]; m_pc = (m_pc + 1) % 8; end
      3: begin m_reg[d] = m_reg[s1] ^ m_reg[s2]; m_pc = (m_pc + 1) % 8; end
      4: begin m_reg[d] = (m_reg[s1] + 16 - m_reg[s2]) % 16; m_pc = (m_pc + 1) % 8; end
      5: begin m_reg[d] = (s1 * 8 + s2) % 16; m_pc = (m_pc + 1) % 8; end
      6: m_pc = (m_pc + 1) % 8;
      default: m_halt = 1'b1;
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; out_ready = 1'b0;
    w_start = 1'b0; w_prog_we = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) m_reg[i] = (i == 0) ? 1 : 0;
    m_pc = 0; m_halt = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc_out, 0);
    check("rst_retire", retire, 0);
    check("rst_jmp", jmp_taken, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
  endtask

  task automatic load_prog(input logic [11:0] p [8]);
    for (int i = 0; i < 8; i++) begin
      prog_we = 1'b1; prog_addr = 3'(i); prog_wdata = p[i]; m_prog[i] = p[i];
      @(negedge clk);
    end
    prog_we = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int k;
    k = 0;
    while (!halted && k < budget) begin @(negedge clk); k++; end
    check("wait_halt", halted, 1);
  endtask

  // Starts the core and follows it retire by retire against the model. A junk program
  // write is issued while busy; it must be dropped, so the model's program is left alone.
  task automatic run_prog(input bit rand_ready, input int max_ret, input bit wr_at_start,
                          input int sw_addr, input logic [11:0] sw_data,
                          output int n_ret, output int n_jmp, output int last_pc);
    int cyc, last_ret, op, budget;
    bit jumped, done;
    logic [11:0] w;
    logic [3:0] last_out;
    n_ret = 0; n_jmp = 0; last_pc = -1; cyc = 0; last_ret = 0; done = 1'b0; last_out = '0;
    budget = max_ret * 12 + 20;
    outs.delete();
    start = 1'b1;
    if (wr_at_start) begin
      prog_we = 1'b1; prog_addr = sw_addr[2:0]; prog_wdata = sw_data; m_prog[sw_addr] = sw_data;
    end
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0; m_pc = 0; m_halt = 1'b0;
    check("busy_after_start", busy, 1);
    check("halted_cleared", halted, 0);
    while (!done) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == 0) begin
        prog_we = 1'b1; prog_addr = 3'($urandom_range(0, 7)); prog_wdata = 12'($urandom);
      end
      @(negedge clk);
      prog_we = 1'b0;
      cyc++;
      w = m_prog[m_pc];
      op = int'(w[11:9]);
      if (out_valid) begin
        check("out_valid_only_for_out", op, 6);
        check("out_data", out_data, m_reg[w[8:6]]);
        last_out = out_data;
      end
      if (retire) begin
        model_step(jumped);
        n_ret++;
        if (jumped) n_jmp++;
        last_pc = int'(pc_out);
        if (op == 6) outs.push_back(int'(last_out));
        check("pc_after_retire", pc_out, m_pc);
        check("jmp_taken", jmp_taken, jumped);
        check("halted_at_retire", halted, m_halt);
        check("busy_at_retire", busy, !m_halt);
        check("out_valid_low_at_retire", out_valid, 0);
        if (!rand_ready) check("latency", cyc - last_ret, (op == 6) ? 3 : 2);
        last_ret = cyc;
        if (m_halt || n_ret >= max_ret) done = 1'b1;
      end else begin
        check("jmp_without_retire", jmp_taken, 0);
      end
      if (!done && cyc >= budget) begin
        check("run_timeout", n_ret, max_ret);
        done = 1'b1;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] p [8];
    int nr, nj, lp, k;

    // 1: ADD r0,r0->r1; OUT r1; HALT
    do_reset();
    p = '{enc(0,0,0,1), enc(6,1,0,0), enc(7,0,0,0), enc(7,0,0,0),
          enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0)};
    load_prog(p);
    run_prog(1'b0, 20, 1'b0, 0, '0, nr, nj, lp);
    check("t1_out_count", outs.size(), 1);
    check("t1_out_data", outs[0], 2);
    check("t1_retires", nr, 3);
    check("t1_halted", halted, 1);
    check("t1_pc", pc_out, 2);
    // restart from halted with a same-cycle write of OUT r0 at address 1
    run_prog(1'b0, 20, 1'b1, 1, enc(6,0,0,0), nr, nj, lp);
    check("t1b_out_data", outs[0], 1);
    check("t1b_pc", pc_out, 2);

    // 2: LDI 5->r2; JMZ r3,r2 (taken), then with r3 preloaded to 1 (not taken)
    do_reset();
    p = '{enc(5,0,5,2), enc(1,3,2,0), enc(7,0,0,0), enc(7,0,0,0),
          enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0)};
    load_prog(p);
    run_prog(1'b0, 20, 1'b0, 0, '0, nr, nj, lp);
    check("t2_jumps", nj, 1);
    check("t2_pc", pc_out, 5);
    check("t2_retires", nr, 3);
    do_reset();
    p = '{enc(5,0,1,3), enc(5,0,5,2), enc(1,3,2,0), enc(7,0,0,0),
          enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0)};
    load_prog(p);
    run_prog(1'b0, 20, 1'b0, 0, '0, nr, nj, lp);
    check("t2b_jumps", nj, 0);
    check("t2b_pc", pc_out, 3);

    // 3: arithmetic wrap and pc wrap from 7 to 0
    do_reset();
    p = '{enc(5,1,7,1), enc(5,0,2,2), enc(0,1,2,3), enc(6,3,0,0),
          enc(4,2,1,4), enc(6,4,0,0), enc(5,0,0,5), enc(3,1,2,6)};
    load_prog(p);
    run_prog(1'b0, 8, 1'b0, 0, '0, nr, nj, lp);
    check("t3_out_count", outs.size(), 2);
    check("t3_add_wrap", outs[0], 1);
    check("t3_sub_wrap", outs[1], 3);
    check("t3_pc_wrap", lp, 0);

    // 4: OUT held while ready is low
    do_reset();
    p = '{enc(6,0,0,0), enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0),
          enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0)};
    load_prog(p);
    out_ready = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t4_valid", out_valid, 1);
    check("t4_data", out_data, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_data", out_data, 1);
      check("t4_no_retire", retire, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_retire", retire, 1);
    check("t4_valid_drop", out_valid, 0);
    check("t4_pc", pc_out, 1);
    wait_halt(10);

    // 5a: program write while busy is dropped
    start = 1'b1; @(negedge clk); start = 1'b0;
    prog_we = 1'b1; prog_addr = 3'd0; prog_wdata = enc(6,1,0,0);
    @(negedge clk); prog_we = 1'b0;
    wait_halt(20);
    run_prog(1'b0, 10, 1'b0, 0, '0, nr, nj, lp);
    check("t5_ram_unchanged", outs[0], 1);

    // 5b: reset while waiting in OUT
    do_reset();
    p = '{enc(6,0,0,0), enc(5,0,3,0), enc(7,0,0,0), enc(7,0,0,0),
          enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0)};
    load_prog(p);
    run_prog(1'b0, 10, 1'b0, 0, '0, nr, nj, lp);
    check("t5_first_out", outs[0], 1);
    out_ready = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    check("t5_valid_before_rst", out_valid, 1);
    check("t5_data_before_rst", out_data, 3);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_pc", pc_out, 0);
    for (int i = 0; i < 8; i++) m_reg[i] = (i == 0) ? 1 : 0;
    run_prog(1'b0, 10, 1'b0, 0, '0, nr, nj, lp);
    check("t5_r0_after_rst", outs[0], 1);

    // random programs against the model
    for (int t = 0; t < 24; t++) begin
      do_reset();
      for (int i = 0; i < 8; i++) begin
        int op;
        op = $urandom_range(0, 7);
        if (op == 7 && $urandom_range(0, 3) != 0) op = 0;
        p[i] = enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      end
      if ($urandom_range(0, 1) == 1) p[7] = enc(7, 0, 0, 0);
      load_prog(p);
      run_prog(t[0], 40, 1'($urandom_range(0, 1)), $urandom_range(0, 7), 12'($urandom),
               nr, nj, lp);
    end

    // 6: wide instance, LDI 0xAB->r15 then OUT r15
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w_prog_we = 1'b1; w_prog_addr = 4'(i);
      w_prog_wdata = (i == 0) ? {3'd5, 4'hA, 4'hB, 4'hF} :
                     (i == 1) ? {3'd6, 4'hF, 4'h0, 4'h0} : {3'd7, 12'h000};
      @(negedge clk);
    end
    w_prog_we = 1'b0; w_out_ready = 1'b1;
    w_start = 1'b1; @(negedge clk); w_start = 1'b0;
    k = 0;
    while (!w_out_valid && k < 20) begin @(negedge clk); k++; end
    check("t6_valid", w_out_valid, 1);
    check("t6_data", w_out_data, 8'hAB);
    k = 0;
    while (!w_halted && k < 20) begin @(negedge clk); k++; end
    check("t6_halted", w_halted, 1);
    check("t6_pc", w_pc_out, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
